// File: rtl/int_ctrl_cp0.sv
// int_ctrl_cp0: interrupt controller sitting in front of the CP0 register block.
//
// Synchronises the raw interrupt lines and latches their rising edges as pending.
// At an instruction boundary it picks the highest-priority enabled source (lowest
// index wins). It then writes the return address into CP0 EPC and redirects the
// pipeline to that source's handler vector. Only one source is serviced at a time;
// ERET ends service.
//
// Ports:
//   clk          in   system clock, rising edge
//   clr          in   asynchronous active-high reset
//   irq_req      in   raw external requests (asynchronous, rising edge significant)
//   int_en       in   global interrupt enable
//   mask         in   per-source enable, 1 = enabled
//   stall        in   pipeline not at a takeable boundary this cycle
//   pc_next      in   address of the next instruction to execute
//   eret         in   ERET executing this cycle
//   EPC_in       out  return address to CP0 EPC
//   EPC_WE       out  one-cycle EPC write strobe
//   int_take     out  pipeline redirect pulse, coincident with EPC_WE
//   handler_addr out  redirect target, valid while int_take = 1
//   in_service   out  one-hot source currently being serviced
//   pending      out  latched pending requests
module int_ctrl_cp0 #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      NIRQ         = 3,
  parameter logic [WIDTH-1:0] HANDLER_BASE = WIDTH'(32'h0000_0800),
  parameter logic [WIDTH-1:0] VEC_STRIDE   = WIDTH'(32'h0000_0100)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [NIRQ-1:0]  irq_req,
  input  logic             int_en,
  input  logic [NIRQ-1:0]  mask,
  input  logic             stall,
  input  logic [WIDTH-1:0] pc_next,
  input  logic             eret,
  output logic [WIDTH-1:0] EPC_in,
  output logic             EPC_WE,
  output logic             int_take,
  output logic [WIDTH-1:0] handler_addr,
  output logic [NIRQ-1:0]  in_service,
  output logic [NIRQ-1:0]  pending
);

  localparam int unsigned IdxW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StTake,
    StService,
    StRet
  } state_e;

  // Synchroniser and edge-detect pipeline
  logic [NIRQ-1:0] sync1_q, sync2_q, prev_q, rise_q;

  // Pending latch
  logic [NIRQ-1:0] pending_q, pending_d;

  // FSM and registered outputs
  state_e          state_q;
  logic [WIDTH-1:0] epc_q;
  logic [WIDTH-1:0] handler_q;
  logic             epc_we_q;
  logic             take_q;
  logic [NIRQ-1:0]  in_service_q;

  // Arbitration
  logic [NIRQ-1:0]  eligible;
  logic [IdxW-1:0]  win_idx;
  logic [NIRQ-1:0]  win_oh;
  logic             take_now;
  logic [WIDTH-1:0] win_handler;

  // Two-flop synchroniser followed by a registered rising-edge detector.
  // A rise stable before edge k shows up in pending at edge k+3.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      rise_q  <= '0;
    end else begin
      sync1_q <= irq_req;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  // Lowest enabled index wins. int_en gates the whole set.
  always_comb begin
    eligible = int_en ? (pending_q & mask) : '0;
    win_idx  = '0;
    win_oh   = '0;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_idx   = IdxW'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  // Modulo-2^WIDTH vector computation
  assign win_handler = HANDLER_BASE + (WIDTH'(win_idx) * VEC_STRIDE);

  assign take_now = (state_q == StIdle) && (|eligible) && !stall;

  // A fresh edge landing on the clear edge wins, so the request is not lost.
  always_comb begin
    pending_d = pending_q;
    if (take_now) begin
      pending_d = pending_d & ~win_oh;
    end
    pending_d = pending_d | rise_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Control FSM with all outputs registered. A clr during StTake kills the
  // EPC write because the strobe flop is reset along with the state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= StIdle;
      epc_q        <= '0;
      handler_q    <= '0;
      epc_we_q     <= 1'b0;
      take_q       <= 1'b0;
      in_service_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (take_now) begin
            state_q      <= StTake;
            epc_q        <= pc_next;
            handler_q    <= win_handler;
            in_service_q <= win_oh;
            epc_we_q     <= 1'b1;
            take_q       <= 1'b1;
          end
        end
        StTake: begin
          // Strobes last one cycle; EPC_in and handler_addr hold.
          state_q  <= StService;
          epc_we_q <= 1'b0;
          take_q   <= 1'b0;
        end
        StService: begin
          // No nesting: mask and int_en are ignored here.
          if (eret) begin
            state_q      <= StRet;
            in_service_q <= '0;
          end
        end
        StRet: begin
          // One dead cycle so the return instruction executes before any retake.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign EPC_in       = epc_q;
  assign EPC_WE       = epc_we_q;
  assign int_take     = take_q;
  assign handler_addr = handler_q;
  assign in_service   = in_service_q;
  assign pending      = pending_q;

endmodule

// File: doc/int_ctrl_cp0.md
Name: int_ctrl_cp0

Overview:
- Interrupt controller directly upstream of the CP0 register block in the MIPS CPU.
- Synchronises external interrupt request lines, latches them as pending, and selects the highest-priority enabled source at an instruction boundary.
- On a take, drives the CP0 EPC write port (EPC_in/EPC_WE) with the return address and redirects the pipeline to a per-source handler vector.
- Tracks the in-service source until ERET; no nesting.

Parameters:
WIDTH, 32, data/address width; matches CP0 WIDTH
NIRQ, 3, number of interrupt sources; index 0 is highest priority
HANDLER_BASE, 32'h0000_0800, handler address of source 0
VEC_STRIDE, 32'h0000_0100, address spacing between handler vectors

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-high reset
irq_req  in  NIRQ  raw external requests, asynchronous, rising-edge significant
int_en  in  1  global interrupt enable
mask  in  NIRQ  per-source enable, 1 = enabled
stall  in  1  pipeline not at a takeable boundary this cycle
pc_next  in  WIDTH  address of the next instruction to execute
eret  in  1  ERET executing this cycle
EPC_in  out  WIDTH  return address to CP0 EPC
EPC_WE  out  1  EPC write strobe to CP0, one-cycle pulse
int_take  out  1  pipeline redirect pulse, coincident with EPC_WE
handler_addr  out  WIDTH  redirect target, valid while int_take=1
in_service  out  NIRQ  one-hot source currently being serviced
pending  out  NIRQ  latched pending requests

Behaviour:
- Single clock domain on clk; clr is asynchronous and active-high, with priority over everything.
- Reset values: all outputs 0; state IDLE; synchroniser and edge-detect flops 0.
- Each irq_req bit passes through a 2-flop synchroniser followed by a registered edge detector.
- pending[i] sets on a synchronised rising edge. A level held high sets it only once.
- pending[i] clears on the clock edge that enters TAKE for source i.
- If a set and a clear of the same bit coincide, the set wins and the bit stays 1.
- Request latency: an irq_req rise at edge k (stable before edge k) sets pending[i] at edge k+3.
- Eligible set: pending & mask, qualified by int_en. The winner is the lowest index in that set.
- States: IDLE, TAKE, SERVICE, RET. All outputs are registered.
- IDLE: if the eligible set is nonzero and stall=0, go to TAKE at the next edge with:
  - EPC_in = pc_next sampled in that cycle;
  - handler_addr = HANDLER_BASE + winner*VEC_STRIDE (WIDTH bits, wrap modulo 2^WIDTH);
  - in_service = onehot(winner).
  Otherwise stay in IDLE. stall=1 defers the take with no loss of pending.
- TAKE: lasts exactly one cycle with EPC_WE=1 and int_take=1, then goes to SERVICE. EPC_in and handler_addr hold until the next take.
- SERVICE:
  - New edges still set pending, but nothing is taken.
  - Changes to mask or int_en have no effect.
  - eret=1 goes to RET and clears in_service to 0.
- RET: lasts one cycle and always goes to IDLE. This guarantees at least one instruction executes at the return address before any retake.
- eret in IDLE, TAKE or RET is ignored.
- clr in any state, including TAKE, aborts immediately to reset values. The pending EPC write does not occur.

Test Plan:
- Reset: assert clr mid-SERVICE -> all outputs 0 and state IDLE within the same cycle; a later eret is ignored.
- Single take: mask=3'b111, int_en=1, pc_next=32'h0000_0040, pulse irq_req[1] -> pending[1] set after 3 edges; next edge EPC_WE=int_take=1 for 1 cycle, EPC_in=32'h40, handler_addr=32'h0900, in_service=3'b010, pending[1]=0.
- Priority and mask: irq 0 and 2 arrive together with mask=3'b110 -> source 2 taken, handler 32'h0A00; pending[0] remains 1.
- Stall and disable: pending[0]=1 with stall=1 for 5 cycles, or int_en=0 -> no EPC_WE. Release -> take on the next edge with pc_next from the release cycle.
- No nesting, then return: during SERVICE raise irq 0 -> pending[0]=1 but no take. eret -> in_service=0; RET one cycle; IDLE; irq 0 taken on the following edge, never earlier.
- Set/clear collision: a new edge on irq 1 lands exactly on the TAKE-entry edge for source 1 -> pending[1]=1 afterwards, and the source is retaken after eret.
